// File: rtl/feeder_pkg.sv
// Shared types and default sizing for the operand feeder and its byte FIFO.
package feeder_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, FIN} feeder_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_GROUP   = 3;
    localparam int DEF_GAP     = 0;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with combinational head data and occupancy count.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Frame sequencer: buffers source bytes and issues GROUP put strobes per start,
// then waits (bounded) for the accumulator's done flag.
//   state | meaning
//   IDLE  | no frame; start begins one
//   ISSUE | issue a put whenever the FIFO holds a byte
//   GAP   | idle spacing between consecutive puts
//   WAIT  | all puts issued, waiting for acc_done with timeout
//   FIN   | emit the frame_done pulse
module operand_feeder #(
    parameter int WIDTH   = feeder_pkg::DEF_WIDTH,
    parameter int DEPTH   = feeder_pkg::DEF_DEPTH,
    parameter int GROUP   = feeder_pkg::DEF_GROUP,
    parameter int GAP     = feeder_pkg::DEF_GAP,
    parameter int TIMEOUT = feeder_pkg::DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       start,
    input  logic                       acc_done,
    output logic                       put,
    output logic [WIDTH-1:0]           value,
    output logic                       busy,
    output logic                       frame_done,
    output logic [$clog2(GROUP+1)-1:0] issued,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);
    localparam int IW = $clog2(GROUP+1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    feeder_pkg::feeder_state_t state_q, state_d;
    logic [IW-1:0]    issued_q, issued_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             put_q, put_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;

    byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .pop_i   (pop),
        .wdata_i (in_data),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= feeder_pkg::IDLE;
            issued_q     <= '0;
            gap_cnt_q    <= '0;
            tmr_q        <= '0;
            put_q        <= 1'b0;
            value_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            gap_cnt_q    <= gap_cnt_d;
            tmr_q        <= tmr_d;
            put_q        <= put_d;
            value_q      <= value_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        gap_cnt_d    = gap_cnt_q;
        tmr_d        = tmr_q;
        put_d        = 1'b0;
        value_d      = value_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        pop          = 1'b0;

        // A start that lands on any non-idle cycle, including the one leaving FIN, is dropped.
        if (start && state_q != feeder_pkg::IDLE) err_d = 1'b1;

        unique case (state_q)
            feeder_pkg::IDLE: begin
                if (start) begin
                    state_d  = feeder_pkg::ISSUE;
                    issued_d = '0;
                end
            end
            feeder_pkg::ISSUE: begin
                if (!fifo_empty) begin
                    put_d    = 1'b1;
                    value_d  = fifo_head;
                    pop      = 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_q == IW'(GROUP - 1)) begin
                        state_d = feeder_pkg::WAIT;
                        tmr_d   = TW'(TIMEOUT - 1);
                    end else if (GAP > 0) begin
                        state_d   = feeder_pkg::GAP;
                        gap_cnt_d = GW'(GAP - 1);
                    end
                end
            end
            feeder_pkg::GAP: begin
                if (gap_cnt_q == '0) state_d = feeder_pkg::ISSUE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            feeder_pkg::WAIT: begin
                if (acc_done) begin
                    state_d = feeder_pkg::FIN;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = feeder_pkg::IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            feeder_pkg::FIN: begin
                frame_done_d = 1'b1;
                state_d      = feeder_pkg::IDLE;
            end
            default: state_d = feeder_pkg::IDLE;
        endcase
    end

    assign in_ready   = !fifo_full;
    assign put        = put_q;
    assign value      = value_q;
    assign busy       = (state_q != feeder_pkg::IDLE);
    assign frame_done = frame_done_q;
    assign issued     = issued_q;
    assign err        = err_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Drives two feeders (GAP=0 and GAP=2) with shared stimulus and compares every
// cycle against a queue-based reference of the frame rules.
module tb_operand_feeder;
    localparam int DEPTH   = 4;
    localparam int GROUP   = 3;
    localparam int TIMEOUT = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_SPACE = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_FIN   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       start;
    logic       acc_done;

    logic       in_ready_w [2];
    logic       put_w      [2];
    logic [7:0] value_w    [2];
    logic       busy_w     [2];
    logic       fd_w       [2];
    logic [1:0] issued_w   [2];
    logic [2:0] level_w    [2];
    logic       err_w      [2];

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mq [2][$];
    int         m_ph   [2];
    int         m_iss  [2];
    int         m_gcnt [2];
    int         m_tmr  [2];
    logic       m_put  [2];
    logic       m_fd   [2];
    logic       m_err  [2];
    logic [7:0] m_val  [2];

    always #5 clk = ~clk;

    operand_feeder #(.WIDTH(8), .DEPTH(DEPTH), .GROUP(GROUP), .GAP(0), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[0]),
        .start(start), .acc_done(acc_done), .put(put_w[0]), .value(value_w[0]), .busy(busy_w[0]),
        .frame_done(fd_w[0]), .issued(issued_w[0]), .level(level_w[0]), .err(err_w[0])
    );

    operand_feeder #(.WIDTH(8), .DEPTH(DEPTH), .GROUP(GROUP), .GAP(2), .TIMEOUT(TIMEOUT)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[1]),
        .start(start), .acc_done(acc_done), .put(put_w[1]), .value(value_w[1]), .busy(busy_w[1]),
        .frame_done(fd_w[1]), .issued(issued_w[1]), .level(level_w[1]), .err(err_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ph[k]   = PH_IDLE;
            m_iss[k]  = 0;
            m_gcnt[k] = 0;
            m_tmr[k]  = 0;
            m_put[k]  = 1'b0;
            m_fd[k]   = 1'b0;
            m_err[k]  = 1'b0;
            m_val[k]  = 8'h00;
        end
    endtask

    // Advance the reference by one rising edge using the inputs present at that edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int gap;
            int old_sz;
            gap    = (k == 0) ? 0 : 2;
            old_sz = mq[k].size();
            m_put[k] = 1'b0;
            m_fd[k]  = 1'b0;
            if (start && m_ph[k] != PH_IDLE) m_err[k] = 1'b1;
            case (m_ph[k])
                PH_IDLE: begin
                    if (start) begin
                        m_ph[k]  = PH_ISSUE;
                        m_iss[k] = 0;
                    end
                end
                PH_ISSUE: begin
                    if (old_sz > 0) begin
                        m_put[k] = 1'b1;
                        m_val[k] = mq[k].pop_front();
                        m_iss[k]++;
                        if (m_iss[k] == GROUP) begin
                            m_ph[k]  = PH_WAIT;
                            m_tmr[k] = 0;
                        end else if (gap > 0) begin
                            m_ph[k]   = PH_SPACE;
                            m_gcnt[k] = 0;
                        end
                    end
                end
                PH_SPACE: begin
                    m_gcnt[k]++;
                    if (m_gcnt[k] == gap) m_ph[k] = PH_ISSUE;
                end
                PH_WAIT: begin
                    if (acc_done) begin
                        m_ph[k] = PH_FIN;
                    end else if (m_tmr[k] == TIMEOUT - 1) begin
                        m_err[k] = 1'b1;
                        m_ph[k]  = PH_IDLE;
                    end else begin
                        m_tmr[k]++;
                    end
                end
                PH_FIN: begin
                    m_fd[k] = 1'b1;
                    m_ph[k] = PH_IDLE;
                end
                default: ;
            endcase
            if (in_valid && old_sz < DEPTH) mq[k].push_back(in_data);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "g0" : "g2";
            check_eq({p, ".put"},        put_w[k],      m_put[k]);
            check_eq({p, ".value"},      value_w[k],    m_val[k]);
            check_eq({p, ".busy"},       busy_w[k],     m_ph[k] != PH_IDLE);
            check_eq({p, ".frame_done"}, fd_w[k],       m_fd[k]);
            check_eq({p, ".issued"},     issued_w[k],   m_iss[k]);
            check_eq({p, ".level"},      level_w[k],    mq[k].size());
            check_eq({p, ".in_ready"},   in_ready_w[k], mq[k].size() < DEPTH);
            check_eq({p, ".err"},        err_w[k],      m_err[k]);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic a);
        in_valid = v;
        in_data  = d;
        start    = s;
        acc_done = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, a);
    endtask

    // Reset asserted between edges, held across one edge, released on the next falling edge.
    task automatic apply_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        acc_done = 1'b0;
        reset    = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        acc_done = 1'b0;
        reset    = 1'b1;
        model_reset();
        @(negedge clk);
        apply_reset();

        // back-to-back frame of three
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(12, 1'b1);

        // start on empty FIFO, bytes trickle in
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(5, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(4, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        idle(6, 1'b0);
        idle(4, 1'b1);

        // fill to full with no start, then drain one frame
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(10, 1'b0);
        idle(4, 1'b1);

        // acc_done timeout plus a start while busy
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        idle(30, 1'b0);

        // reset in the middle of a frame, then a fresh frame
        apply_reset();
        cycle(1'b1, 8'h71, 1'b0, 1'b0);
        cycle(1'b1, 8'h72, 1'b0, 1'b0);
        cycle(1'b1, 8'h73, 1'b1, 1'b0);
        idle(2, 1'b0);
        apply_reset();
        cycle(1'b1, 8'h81, 1'b1, 1'b0);
        cycle(1'b1, 8'h82, 1'b0, 1'b0);
        cycle(1'b1, 8'h83, 1'b0, 1'b0);
        idle(8, 1'b0);
        idle(3, 1'b1);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(299) == 0) begin
                apply_reset();
            end else begin
                cycle(1'($urandom_range(1)), 8'($urandom),
                      $urandom_range(9) == 0, $urandom_range(3) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
